// File: rtl/io_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : io_bus_arbiter
// Brief    : Shares one IODevices port among NUM_REQ requesters, one 3-cycle
//            transaction at a time (IDLE -> ACCESS -> RESP). Round-robin by
//            default; define IO_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
// Revision : 1.0 - initial release
// ============================================================================
module io_bus_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ID_W-1:0]   req_device_id,
    input  logic [NUM_REQ*DATA_W-1:0] req_value,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_value,
    output logic [ID_W-1:0]           io_device_id,
    output logic [DATA_W-1:0]         io_value_in,
    output logic                      io_is_write,
    input  logic [DATA_W-1:0]         io_value_out,
    output logic                      busy
);
    localparam int         c_IDX_W     = (NUM_REQ > 2) ? 2 : 1;
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCESS = 2'd1;
    localparam logic [1:0] c_ST_RESP   = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [c_IDX_W-1:0] r_winner;
    logic [c_IDX_W-1:0] w_start;
    logic [c_IDX_W-1:0] w_win;
    logic [NUM_REQ-1:0] w_onehot;
    logic               w_any;
    logic               w_accept;
    logic               w_sel_write;
    logic [ID_W-1:0]    w_sel_id;
    logic [DATA_W-1:0]  w_sel_value;
    logic [DATA_W-1:0]  r_rsp_data;

`ifdef IO_ARB_FIXED_PRIO_EN
    assign w_start = '0;
`else
    logic [c_IDX_W-1:0] r_rr_ptr;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rr_ptr <= '0;
        end else if (w_accept) begin
            r_rr_ptr <= (w_win == c_IDX_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
        end
    end

    assign w_start = r_rr_ptr;
`endif

    // Offsets are scanned from farthest to nearest so the requester closest
    // to the search start is the last (winning) assignment.
    always_comb begin
        w_any       = 1'b0;
        w_win       = '0;
        w_onehot    = '0;
        w_sel_write = 1'b0;
        w_sel_id    = '0;
        w_sel_value = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (req_valid[j] && (j == (int'(w_start) + off) % NUM_REQ)) begin
                    w_any       = 1'b1;
                    w_win       = c_IDX_W'(j);
                    w_onehot    = '0;
                    w_onehot[j] = 1'b1;
                    w_sel_write = req_write[j];
                    w_sel_id    = req_device_id[j*ID_W +: ID_W];
                    w_sel_value = req_value[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign w_accept = reset_n && (r_state == c_ST_IDLE) && w_any;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = c_ST_IDLE;
        case (r_state)
            c_ST_IDLE:   w_next_state = w_any ? c_ST_ACCESS : c_ST_IDLE;
            c_ST_ACCESS: w_next_state = c_ST_RESP;
            c_ST_RESP:   w_next_state = c_ST_IDLE;
            default:     w_next_state = c_ST_IDLE;
        endcase
    end

    // io_is_write doubles as the latched write flag during ACCESS.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_winner     <= '0;
            r_rsp_data   <= '0;
            io_device_id <= '0;
            io_value_in  <= '0;
            io_is_write  <= 1'b0;
        end else if (w_accept) begin
            r_winner     <= w_win;
            io_device_id <= w_sel_id;
            io_value_in  <= w_sel_value;
            io_is_write  <= w_sel_write;
        end else if (r_state == c_ST_ACCESS) begin
            r_rsp_data   <= io_is_write ? '0 : io_value_out;
            io_is_write  <= 1'b0;
        end
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        rsp_value = '0;
        busy      = (r_state != c_ST_IDLE);
        if (reset_n && (r_state == c_ST_IDLE)) begin
            req_ready = w_onehot;
        end
        if (r_state == c_ST_RESP) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                rsp_valid[k] = (r_winner == c_IDX_W'(k));
            end
            rsp_value = r_rsp_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_io_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_bus_arbiter
// Brief    : Self-checking bench for io_bus_arbiter with a device-memory model
//            and a transaction-level arbitration/memory reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_bus_arbiter;
    localparam int NUM_REQ = 2;
    localparam int DATA_W  = 32;
    localparam int ID_W    = 8;

    logic                      clk = 1'b0;
    logic                      reset_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ID_W-1:0]   req_device_id;
    logic [NUM_REQ*DATA_W-1:0] req_value;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_value;
    logic [ID_W-1:0]           io_device_id;
    logic [DATA_W-1:0]         io_value_in;
    logic                      io_is_write;
    logic [DATA_W-1:0]         io_value_out;
    logic                      busy;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] dev_mem [256];
    logic [255:0]      dev_written;
    logic              mem_clr;
    logic [DATA_W-1:0] ref_mem [256];
    int                ref_ptr;

    always #5 clk = ~clk;

    io_bus_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_device_id (req_device_id),
        .req_value     (req_value),
        .rsp_valid     (rsp_valid),
        .rsp_value     (rsp_value),
        .io_device_id  (io_device_id),
        .io_value_in   (io_value_in),
        .io_is_write   (io_is_write),
        .io_value_out  (io_value_out),
        .busy          (busy)
    );

    // IODevices stand-in: commits on the edge, reads combinationally; unwritten
    // locations return a per-id default pattern.
    always @(posedge clk) begin
        if (mem_clr) begin
            dev_written <= '0;
        end else if (io_is_write) begin
            dev_mem[io_device_id]     <= io_value_in;
            dev_written[io_device_id] <= 1'b1;
        end
    end
    assign io_value_out = dev_written[io_device_id] ? dev_mem[io_device_id]
                                                    : (32'hA000_0000 | 32'(io_device_id));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int predict(input logic [NUM_REQ-1:0] v);
        int k;
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef IO_ARB_FIXED_PRIO_EN
            k = i;
`else
            k = (ref_ptr + i) % NUM_REQ;
`endif
            if (((v >> k) & 1'b1) != 0) return k;
        end
        return -1;
    endfunction

    task automatic set_req(input int r, input logic v, input logic wr,
                           input logic [ID_W-1:0] id, input logic [DATA_W-1:0] val);
        req_valid[r]                     = v;
        req_write[r]                     = wr;
        req_device_id[r*ID_W +: ID_W]    = id;
        req_value[r*DATA_W +: DATA_W]    = val;
    endtask

    // Called at a negedge in IDLE with at least one request valid; returns at
    // the negedge after the response cycle.
    task automatic expect_txn(input bit drop, output logic [NUM_REQ-1:0] got_rsp,
                              output logic [DATA_W-1:0] got_val);
        int                w;
        logic              ew;
        logic [ID_W-1:0]   eid;
        logic [DATA_W-1:0] ev;
        logic [DATA_W-1:0] er;
        #1;
        w   = predict(req_valid);
        ew  = ((req_write >> w) & 1'b1) != 0;
        eid = req_device_id[w*ID_W +: ID_W];
        ev  = req_value[w*DATA_W +: DATA_W];
        er  = ew ? '0 : ref_mem[eid];
        chk("idle_busy", busy, 0);
        chk("grant", req_ready, NUM_REQ'(1) << w);
        @(negedge clk);
        if (drop) req_valid[w] = 1'b0;
        chk("acc_is_write", io_is_write, ew);
        chk("acc_dev_id", io_device_id, eid);
        chk("acc_value_in", io_value_in, ev);
        chk("acc_busy", busy, 1);
        chk("acc_ready", req_ready, 0);
        chk("acc_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        got_rsp = rsp_valid;
        got_val = rsp_value;
        chk("rsp_valid", rsp_valid, NUM_REQ'(1) << w);
        chk("rsp_value", rsp_value, er);
        chk("rsp_is_write", io_is_write, 0);
        chk("rsp_ready", req_ready, 0);
        chk("rsp_busy", busy, 1);
        if (ew) ref_mem[eid] = ev;
        ref_ptr = (w + 1) % NUM_REQ;
        @(negedge clk);
        chk("post_rsp_valid", rsp_valid, 0);
        chk("post_rsp_value", rsp_value, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NUM_REQ-1:0] g;
        logic [DATA_W-1:0]  v;
        logic [NUM_REQ-1:0] t4_tbl [4];

`ifdef IO_ARB_FIXED_PRIO_EN
        t4_tbl[0] = 2'b01; t4_tbl[1] = 2'b01; t4_tbl[2] = 2'b01; t4_tbl[3] = 2'b01;
`else
        t4_tbl[0] = 2'b01; t4_tbl[1] = 2'b10; t4_tbl[2] = 2'b01; t4_tbl[3] = 2'b10;
`endif
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'hA000_0000 | 32'(i);
        ref_ptr       = 0;
        reset_n       = 1'b0;
        mem_clr       = 1'b1;
        req_valid     = 2'b11;
        req_write     = '0;
        req_device_id = '0;
        req_value     = '0;

        // Reset held two cycles with both requesters asking
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_value", rsp_value, 0);
        chk("rst_io_id", io_device_id, 0);
        chk("rst_io_value", io_value_in, 0);
        chk("rst_io_write", io_is_write, 0);
        reset_n   = 1'b1;
        mem_clr   = 1'b0;
        req_valid = '0;
        @(negedge clk);
        chk("idle_no_req_ready", req_ready, 0);

        // Write then read back through requester 0
        set_req(0, 1'b1, 1'b1, 8'd1, 32'hE5F84AB1);
        expect_txn(1'b1, g, v);
        set_req(0, 1'b1, 1'b0, 8'd1, 32'h0);
        expect_txn(1'b1, g, v);
        chk("t2_readback", v, 32'hE5F84AB1);

        // A different device does not alias
        set_req(0, 1'b1, 1'b0, 8'd0, 32'h0);
        expect_txn(1'b1, g, v);
        chk("t3_isolated", (v !== 32'hE5F84AB1), 1);

        // Bring the pointer back to 0, then continuous contention
        set_req(1, 1'b1, 1'b0, 8'd3, 32'h0);
        expect_txn(1'b1, g, v);
        set_req(0, 1'b1, 1'b0, 8'd4, 32'h1111_0000);
        set_req(1, 1'b1, 1'b1, 8'd5, 32'h2222_0005);
        for (int i = 0; i < 4; i++) begin
            expect_txn(1'b0, g, v);
            chk("t4_order", g, t4_tbl[i]);
        end
        req_valid[0] = 1'b0;
        expect_txn(1'b1, g, v);
        chk("t4_after_drop0", g, 2'b10);
        req_valid = '0;

        // Reset during ACCESS of a write: write lands, response is dropped
        set_req(0, 1'b1, 1'b1, 8'd2, 32'h5C8C6A01);
        #1;
        chk("t5_grant", req_ready, 2'b01);
        @(negedge clk);
        chk("t5_acc_write", io_is_write, 1);
        reset_n   = 1'b0;
        req_valid = '0;
        @(negedge clk);
        chk("t5_rst_rsp", rsp_valid, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_io_write", io_is_write, 0);
        reset_n     = 1'b1;
        ref_mem[2]  = 32'h5C8C6A01;
        ref_ptr     = 0;
        @(negedge clk);
        chk("t5_no_late_rsp", rsp_valid, 0);
        chk("t5_idle_busy", busy, 0);
        set_req(0, 1'b1, 1'b0, 8'd2, 32'h0);
        expect_txn(1'b1, g, v);
        chk("t5_readback", v, 32'h5C8C6A01);

        // Randomized traffic, with idle gaps that must not move the pointer
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                req_valid = '0;
                #1;
                chk("rnd_idle_ready", req_ready, 0);
                @(negedge clk);
                chk("rnd_idle_busy", busy, 0);
                chk("rnd_idle_rsp", rsp_valid, 0);
            end else begin
                for (int r = 0; r < NUM_REQ; r++) begin
                    set_req(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                            8'($urandom_range(0, 7)), $urandom);
                end
                if (req_valid == '0) req_valid[$urandom_range(0, NUM_REQ - 1)] = 1'b1;
                expect_txn(1'($urandom_range(0, 1)), g, v);
            end
        end
        req_valid = '0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
